// File: rtl/temp_alarm_monitor.sv
// temp_alarm_monitor
//   Multi-channel temperature alarm. Each channel runs a debounced
//   NORMAL / WARNING / FIRE state machine driven by strobed samples. FIRE is
//   latched until an acknowledge arrives and the last stored sample has cooled
//   below FIRE_TH-HYST. A shared buzzer beeps while any channel is in FIRE and
//   the alarm has not been muted by an acknowledge.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample_valid  one-cycle strobe qualifying sample_ch / sample_tmp
//   sample_ch     channel index of the sample (CHW bits)
//   sample_tmp    unsigned temperature (W bits)
//   ack           one-cycle acknowledge pulse (IR remote)
//   is_warning    per-channel WARNING flag (NCH bits)
//   is_fire       per-channel FIRE flag (NCH bits)
//   any_warning   OR of is_warning
//   any_fire      OR of is_fire
//   fire_ch       lowest channel index in FIRE, 0 when none
//   buzzer        registered buzzer drive
module temp_alarm_monitor #(
    parameter int NCH       = 4,
    parameter int W         = 8,
    parameter int WARN_TH   = 35,
    parameter int FIRE_TH   = 50,
    parameter int HYST      = 2,
    parameter int DEBOUNCE  = 3,
    parameter int BEEP_HALF = 50_000_000,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sample_valid,
    input  logic [CHW-1:0] sample_ch,
    input  logic [W-1:0]   sample_tmp,
    input  logic           ack,
    output logic [NCH-1:0] is_warning,
    output logic [NCH-1:0] is_fire,
    output logic           any_warning,
    output logic           any_fire,
    output logic [CHW-1:0] fire_ch,
    output logic           buzzer
);

    localparam logic [W-1:0] WARN_V  = W'(WARN_TH);
    localparam logic [W-1:0] FIRE_V  = W'(FIRE_TH);
    localparam logic [W-1:0] WARN_LO = W'(WARN_TH - HYST);
    localparam logic [W-1:0] FIRE_LO = W'(FIRE_TH - HYST);
    localparam logic [3:0]   DEB_V   = 4'(DEBOUNCE);
    localparam int           PW      = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(BEEP_HALF - 1);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_WARNING = 2'd1,
        ST_FIRE    = 2'd2
    } state_t;

    logic [NCH-1:0] enter_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t       state_reg, state_next;
            logic [W-1:0] last_reg;
            logic [3:0]   warn_reg, warn_next, warn_inc;
            logic [3:0]   fire_reg, fire_next, fire_inc;
            logic         hit;

            // Equality against this channel's index also rejects any index
            // >= NCH, since no channel instance exists for it.
            assign hit = sample_valid && (sample_ch == CHW'(gi));

            always_comb begin
                warn_inc   = (sample_tmp >= WARN_V) ?
                             ((warn_reg == DEB_V) ? DEB_V : warn_reg + 4'd1) : 4'd0;
                fire_inc   = (sample_tmp >= FIRE_V) ?
                             ((fire_reg == DEB_V) ? DEB_V : fire_reg + 4'd1) : 4'd0;
                state_next = state_reg;
                warn_next  = warn_reg;
                fire_next  = fire_reg;
                if (hit) begin
                    // A sample for this channel wins over a coincident ack.
                    warn_next = warn_inc;
                    fire_next = fire_inc;
                    if (state_reg != ST_FIRE) begin
                        if (fire_inc == DEB_V) begin
                            state_next = ST_FIRE;
                            warn_next  = 4'd0;
                            fire_next  = 4'd0;
                        end else if (state_reg == ST_NORMAL && warn_inc == DEB_V) begin
                            state_next = ST_WARNING;
                            warn_next  = 4'd0;
                        end else if (state_reg == ST_WARNING && sample_tmp < WARN_LO) begin
                            state_next = ST_NORMAL;
                            warn_next  = 4'd0;
                            fire_next  = 4'd0;
                        end
                    end
                end else if (ack && state_reg == ST_FIRE && last_reg < FIRE_LO) begin
                    state_next = ST_WARNING;
                    warn_next  = 4'd0;
                    fire_next  = 4'd0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_NORMAL;
                    last_reg  <= '0;
                    warn_reg  <= 4'd0;
                    fire_reg  <= 4'd0;
                end else begin
                    state_reg <= state_next;
                    warn_reg  <= warn_next;
                    fire_reg  <= fire_next;
                    if (hit) begin
                        last_reg <= sample_tmp;
                    end
                end
            end

            assign is_warning[gi] = (state_reg == ST_WARNING);
            assign is_fire[gi]    = (state_reg == ST_FIRE);
            assign enter_fire[gi] = (state_next == ST_FIRE) && (state_reg != ST_FIRE);
        end
    endgenerate

    assign any_warning = |is_warning;
    assign any_fire    = |is_fire;

    always_comb begin
        fire_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (is_fire[i]) begin
                fire_ch = CHW'(i);
            end
        end
    end

    // Alarm silencing and buzzer generation.
    logic          mute_reg;
    logic [PW-1:0] phase_reg;
    logic          beep_on;

    assign beep_on = any_fire && !mute_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_reg  <= 1'b0;
            phase_reg <= '0;
            buzzer    <= 1'b0;
        end else begin
            // A fresh FIRE entry re-arms the alarm even against a coincident ack.
            if (|enter_fire) begin
                mute_reg <= 1'b0;
            end else if (ack) begin
                mute_reg <= 1'b1;
            end
            if (beep_on) begin
                // Toggle whenever the phase counter wraps to 0; the first
                // active cycle sees phase 0 with buzzer low, so it starts high.
                if (phase_reg == '0) begin
                    buzzer <= ~buzzer;
                end
                phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
            end else begin
                buzzer    <= 1'b0;
                phase_reg <= '0;
            end
        end
    end

endmodule
